vp_gray: RTL and testbench

Pixel-stream stage between the camera capture block and the Sobel video-processing stage. It converts each RGB444 pixel into a 4-bit luminance value and replicates it on all three channels, so the Sobel stage sees a gray image. It uses a 2-stage elastic pipeline with valid/ready handshakes on both sides. It also tracks the output column and flags end-of-line for the downstream line buffers.

---
 rtl/vp_gray.sv | 77 +++++++
 tb/tb_vp_gray.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vp_gray.sv
// RGB444 to gray conversion stage: two-stage elastic pipeline with valid/ready on
// both sides, plus an output column counter that flags end-of-line.
module vp_gray #(
  parameter int DW = 12,
  parameter int RL = 640
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_data_ready,
  input  logic                  i_data_valid,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_data_ready,
  output logic                  o_data_valid,
  output logic [DW-1:0]         o_data,
  output logic                  o_eol,
  output logic [$clog2(RL)-1:0] o_col
);

  localparam int CW = $clog2(RL);
  localparam logic [CW-1:0] LAST_COL = CW'(RL - 1);

  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic [11:0]   prod_r;
  logic [11:0]   prod_g;
  logic [11:0]   prod_b;
  logic [11:0]   luma_sum;
  logic [3:0]    luma;
  logic [CW-1:0] col_next;

  assign s2_adv       = !s2_valid || i_data_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign o_data_ready = s1_adv;
  assign o_data_valid = s2_valid;

  // Weights sum to 256, so the top nibble of the sum is already the 4-bit luma.
  assign luma_sum = prod_r + prod_g + prod_b;
  assign luma     = luma_sum[11:8];

  // Products are held at 12 bits because the green term reaches 150*15 = 2250.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      prod_r   <= '0;
      prod_g   <= '0;
      prod_b   <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_data_valid;
      if (i_data_valid) begin
        prod_r <= 12'd77  * {8'd0, i_data[11:8]};
        prod_g <= 12'd150 * {8'd0, i_data[7:4]};
        prod_b <= 12'd29  * {8'd0, i_data[3:0]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_valid <= 1'b0;
      o_data   <= '0;
      o_col    <= '0;
      o_eol    <= 1'b0;
      col_next <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_data   <= DW'({luma, luma, luma});
        o_col    <= col_next;
        o_eol    <= (col_next == LAST_COL);
        col_next <= (col_next == LAST_COL) ? '0 : col_next + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vp_gray.sv
// Directed and random-handshake bench for vp_gray; a queue-based scoreboard holds
// the expected gray value, column and eol for every accepted pixel.
module tb_vp_gray;

  localparam int DW = 12;
  localparam int RL = 640;
  localparam int CW = $clog2(RL);

  logic          clk;
  logic          rstn;
  logic          o_data_ready;
  logic          i_data_valid;
  logic [DW-1:0] i_data;
  logic          i_data_ready;
  logic          o_data_valid;
  logic [DW-1:0] o_data;
  logic          o_eol;
  logic [CW-1:0] o_col;

  vp_gray #(.DW(DW), .RL(RL)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .o_data_ready (o_data_ready),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .i_data_ready (i_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_eol        (o_eol),
    .o_col        (o_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;
  int in_count    = 0;
  int out_count   = 0;
  int eol_count   = 0;
  logic [11:0] exp_data_q[$];
  int          exp_col_q[$];

  function automatic logic [11:0] gray_model(input logic [11:0] pix);
    int sum;
    logic [3:0] y;
    sum = 77 * int'(pix[11:8]) + 150 * int'(pix[7:4]) + 29 * int'(pix[3:0]);
    y = 4'(sum >> 8);
    return {y, y, y};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Samples both handshakes just before the rising edge, then returns at the next falling edge.
  task automatic clockCycle();
    logic acc;
    logic outx;
    #1;
    acc  = i_data_valid && o_data_ready;
    outx = o_data_valid && i_data_ready;
    if (outx) begin
      if (exp_data_q.size() == 0) begin
        checkOutput("spurious_output", 32'd1, 32'd0);
      end else begin
        int col;
        col = exp_col_q.pop_front();
        checkOutput("pixel_data", 32'(o_data), 32'(exp_data_q.pop_front()));
        checkOutput("pixel_col", 32'(o_col), 32'(col));
        checkOutput("pixel_eol", 32'(o_eol), 32'(col == RL - 1));
        if (o_eol) eol_count++;
      end
      out_count++;
    end
    if (acc) begin
      exp_data_q.push_back(gray_model(i_data));
      exp_col_q.push_back(in_count % RL);
      in_count++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [11:0] data, input logic ready);
    i_data_valid = valid;
    i_data       = data;
    i_data_ready = ready;
    clockCycle();
  endtask

  task automatic resetModel();
    exp_data_q.delete();
    exp_col_q.delete();
    in_count  = 0;
    out_count = 0;
    eol_count = 0;
  endtask

  task automatic doReset();
    rstn         = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_ready = 1'b1;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  logic [11:0] dir_pix [5];
  logic [11:0] dir_exp [5];

  initial begin
    dir_pix = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};
    dir_exp = '{12'hFFF, 12'h444, 12'h888, 12'h111, 12'h000};

    // Reset values, both during reset and after release with no input.
    rstn         = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(o_data_valid), 32'd0);
    checkOutput("rst_ready", 32'(o_data_ready), 32'd1);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_col", 32'(o_col), 32'd0);
    checkOutput("rst_eol", 32'(o_eol), 32'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 12'h000, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("idle_valid", 32'(o_data_valid), 32'd0);
    checkOutput("idle_ready", 32'(o_data_ready), 32'd1);
    checkOutput("idle_col", 32'(o_col), 32'd0);

    $display("[TB] directed colour bars");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, dir_pix[i], 1'b1);
      if (i == 0) begin
        checkOutput("latency_not_yet", 32'(o_data_valid), 32'd0);
      end else begin
        checkOutput("dir_valid", 32'(o_data_valid), 32'd1);
        checkOutput("dir_data", 32'(o_data), 32'(dir_exp[i-1]));
      end
    end
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("dir_data_tail", 32'(o_data), 32'(dir_exp[4]));
    applyStimulus(1'b0, 12'h000, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("dir_drained", 32'(o_data_valid), 32'd0);
    checkOutput("dir_count", 32'(out_count), 32'd5);

    $display("[TB] line wrap stream");
    doReset();
    for (int i = 0; i < 1300; i++) applyStimulus(1'b1, 12'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("wrap_count", 32'(out_count), 32'd1300);
    checkOutput("wrap_eols", 32'(eol_count), 32'd2);

    $display("[TB] random handshakes");
    doReset();
    begin
      int cycles;
      cycles = 0;
      while (in_count < 5000 && cycles < 60000) begin
        applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
        cycles++;
      end
      if (cycles >= 60000) checkOutput("rand_timeout", 32'd1, 32'd0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("rand_in_count", 32'(in_count), 32'd5000);
    checkOutput("rand_out_count", 32'(out_count), 32'd5000);
    checkOutput("rand_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("[TB] backpressure fill and drain");
    doReset();
    applyStimulus(1'b1, 12'h123, 1'b0);
    checkOutput("bp_ready_one", 32'(o_data_ready), 32'd1);
    applyStimulus(1'b1, 12'hABC, 1'b0);
    checkOutput("bp_ready_full", 32'(o_data_ready), 32'd0);
    applyStimulus(1'b1, 12'h777, 1'b0);
    checkOutput("bp_accepted", 32'(in_count), 32'd2);
    checkOutput("bp_hold_data", 32'(o_data), 32'(gray_model(12'h123)));
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    #1;
    checkOutput("bp_drain_ready", 32'(o_data_ready), 32'd1);
    checkOutput("bp_drain_valid", 32'(o_data_valid), 32'd1);
    clockCycle();
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("bp_drain_count", 32'(out_count), 32'd2);
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("bp_empty", 32'(o_data_valid), 32'd0);

    $display("[TB] reset mid-line");
    doReset();
    while (out_count < 300 && in_count < 400) applyStimulus(1'b1, 12'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 12'($urandom), 1'b0);
    checkOutput("mid_col", 32'(o_col), 32'd300);
    checkOutput("mid_full", 32'(o_data_ready), 32'd0);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(o_data_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(o_data_ready), 32'd1);
    resetModel();
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 12'h0F0, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("mid_first_valid", 32'(o_data_valid), 32'd1);
    checkOutput("mid_first_col", 32'(o_col), 32'd0);
    checkOutput("mid_first_data", 32'(o_data), 32'h888);
    applyStimulus(1'b0, 12'h000, 1'b1);
    checkOutput("mid_out_count", 32'(out_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
